ds_step_fsm: RTL and testbench
==============================

Name: ds_step_fsm

Overview:
- Small Moore state machine stepping through three states under a strobe input `s` and a direction input `d`.
- The state is presented one-hot on a 3-bit registered output `q`.
- Serves as a sequencing/control element: `s` requests a step; `d` selects "advance" (1) or "return to first state" (0).
- Single clock domain; no handshake beyond the strobe.

Parameters:
- WRAP, default 1: 1 = an advance from S3 goes to S1; 0 = an advance from S3 holds in S3 (saturate).

Ports:
- clk  input  1  rising-edge system clock
- rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk
- d    input  1  direction: 1 = advance to next state, 0 = return to S1
- s    input  1  step strobe; qualifies d
- q    output 3  one-hot state encoding, driven directly from a register

Interface (already decided):
- One clock; reset is synchronous and active-high.
- Ports are named clk and rst.

Behaviour:
- States and encodings:
  - S1 = 3'b001
  - S2 = 3'b010
  - S3 = 3'b100
- q always equals the current state register. There is no combinational path from d or s to q (Moore machine).
- Reset:
  - Condition: rst=1 at a rising clk edge.
  - Result: state becomes S1, so q=3'b001 after that edge.
  - Priority: rst overrides d and s.
  - Reset mid-operation: asserting rst while any state is active goes to S1 at the next edge, regardless of s.
- Transitions, evaluated at each rising edge with rst=0:
  - s=0: hold the current state (d ignored).
  - s=1, d=1, from S1: go to S2.
  - s=1, d=1, from S2: go to S3.
  - s=1, d=1, from S3: go to S1 if WRAP=1; stay in S3 if WRAP=0.
  - s=1, d=0, from any state: go to S1 (from S1 this means staying in S1).
- Latency: one cycle. The new state is visible on q immediately after the sampling edge.
- Level-sensitive strobe (default build): s held high for N consecutive edges produces N transitions.
  - Example: from S1 with d=1 held, two edges give S3.
- Simultaneous d/s changes are resolved by the values sampled at the edge. d changes while s=0 have no effect.
- Illegal or unreached encodings (e.g. 3'b000, 3'b011, 3'b111) recover to S1 at the next edge, independent of s and d.
- Before the first reset, state is undefined. The bench must assert rst before checking q.

Optional Feature:
- Macro: DS_STEP_FSM_EDGE_EN
- Defined: s is first registered. A step occurs only on a rising edge of s, i.e. s=1 now and s=0 at the previous clock edge.
  - s held high for several cycles yields exactly one transition.
  - The s history register clears to 0 on rst, so an s already high when rst deasserts counts as a rising edge.
  - Latency from s rising to the q change is still one cycle; the detection is combinational on the current s versus the registered previous s.
- Undefined: level-sensitive behaviour as described above.

Decomposition:
- Shared package ds_step_fsm_pkg contains:
  - state enum/typedef (S1, S2, S3) with the one-hot encoding constants
  - Q_W = 3
- Sub-module step_edge_det: a 1-bit rising-edge detector with synchronous active-high reset.
  - Natural when DS_STEP_FSM_EDGE_EN is defined.
  - Otherwise no sub-module.

Test Plan:
1. Reset: rst=1 for one edge with d=1, s=1 -> q=001 after the edge; then rst=0, s=0 for 3 edges -> q stays 001.
2. Normal advance: from S1, d=1, s=1 for one edge, then s=0 -> q=010, then held at 010 while s=0.
3. Return to S1: from S2, d=0, s=1 for one edge -> q=001; s=0 with d toggling -> q unchanged.
4. Advance through all states:
   - From S1, d=1, s=1 for 3 edges -> q: 010, 100, then 001 (WRAP=1) or 100 (WRAP=0).
   - With DS_STEP_FSM_EDGE_EN: the same stimulus gives q=010 only, holding thereafter.
5. Mixed sequence from S1, one edge each:
   - (d=1, s=1) -> 010
   - (d=0, s=1) -> 001
   - (d=1, s=0) -> 001
6. Reset mid-operation: reach S3, then rst=1 with d=1, s=1 -> q=001 at the next edge; release rst -> normal stepping resumes from S1.

Source files
------------

// File: rtl/ds_step_fsm_pkg.sv
// Shared types for the three-state step sequencer: one-hot state encoding and output width.
package ds_step_fsm_pkg;

    localparam int Q_W = 3;

    typedef enum logic [Q_W-1:0] {
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b100
    } state_t;

endpackage

// File: rtl/step_edge_det.sv
// Rising-edge detector on a 1-bit strobe; output is combinational on the current input versus its registered history.
// Only built with DS_STEP_FSM_EDGE_EN; history clears on rst so a level already high after reset reads as an edge.
`ifdef DS_STEP_FSM_EDGE_EN
module step_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule
`endif

// File: rtl/ds_step_fsm.sv
// Moore step sequencer S1->S2->S3 on strobe s, d=0 returns to S1; q is the one-hot state register, one-cycle latency.
// No backpressure; DS_STEP_FSM_EDGE_EN makes s edge-triggered instead of level-sensitive.
module ds_step_fsm
    import ds_step_fsm_pkg::*;
#(
    parameter int WRAP = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           d,
    input  logic           s,
    output logic [Q_W-1:0] q
);

    state_t r_state;
    logic   w_step;

`ifdef DS_STEP_FSM_EDGE_EN
    step_edge_det u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (s),
        .o_rise (w_step)
    );
`else
    assign w_step = s;
`endif

    // Unreached encodings fall to the default arm and recover regardless of the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S1;
        end else begin
            case (r_state)
                S1: if (w_step) r_state <= d ? S2 : S1;
                S2: if (w_step) r_state <= d ? S3 : S1;
                S3: if (w_step) r_state <= (d && (WRAP == 0)) ? S3 : S1;
                default: r_state <= S1;
            endcase
        end
    end

    assign q = r_state;

endmodule

// File: tb/tb_ds_step_fsm.sv
// Directed bench for ds_step_fsm: a wrapping and a saturating instance share stimulus; expectations are hand-derived.
module tb_ds_step_fsm;

`ifdef DS_STEP_FSM_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       d   = 1'b0;
    logic       s   = 1'b0;
    logic [2:0] q_w;
    logic [2:0] q_s;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ds_step_fsm #(.WRAP(1)) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .s   (s),
        .q   (q_w)
    );

    ds_step_fsm #(.WRAP(0)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .s   (s),
        .q   (q_s)
    );

    task automatic check_q(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Apply inputs away from the edge, clock once, sample 1 time unit after the edge.
    task automatic step(input string tag, input logic r, input logic dd, input logic ss,
                        input logic [2:0] exp_w, input logic [2:0] exp_s);
        rst = r;
        d   = dd;
        s   = ss;
        @(posedge clk);
        #1;
        check_q({tag, "_wrap"}, q_w, exp_w);
        check_q({tag, "_sat"},  q_s, exp_s);
    endtask

    initial begin
        logic [2:0] e;
        #2;
        // 1: reset wins over d/s, then idle holds S1
        step("rst",        1'b1, 1'b1, 1'b1, 3'b001, 3'b001);
        for (int i = 0; i < 3; i++) step("rst_idle", 1'b0, 1'b1, 1'b0, 3'b001, 3'b001);

        // 2: single advance then hold
        step("adv",        1'b0, 1'b1, 1'b1, 3'b010, 3'b010);
        step("adv_hold0",  1'b0, 1'b1, 1'b0, 3'b010, 3'b010);
        step("adv_hold1",  1'b0, 1'b0, 1'b0, 3'b010, 3'b010);

        // 3: return to S1, d toggles with s low
        step("ret",        1'b0, 1'b0, 1'b1, 3'b001, 3'b001);
        step("ret_d1",     1'b0, 1'b1, 1'b0, 3'b001, 3'b001);
        step("ret_d0",     1'b0, 1'b0, 1'b0, 3'b001, 3'b001);
        step("ret_d1b",    1'b0, 1'b1, 1'b0, 3'b001, 3'b001);

        // 4: s held high for three edges
        step("run1",       1'b0, 1'b1, 1'b1, 3'b010, 3'b010);
        e = EDGE ? 3'b010 : 3'b100;
        step("run2",       1'b0, 1'b1, 1'b1, e, e);
        step("run3",       1'b0, 1'b1, 1'b1, EDGE ? 3'b010 : 3'b001, EDGE ? 3'b010 : 3'b100);
        step("run_hold",   1'b0, 1'b1, 1'b0, EDGE ? 3'b010 : 3'b001, EDGE ? 3'b010 : 3'b100);

        // back to S1 for the mixed sequence
        step("home",       1'b0, 1'b0, 1'b1, 3'b001, 3'b001);
        step("home_idle",  1'b0, 1'b0, 1'b0, 3'b001, 3'b001);

        // 5: mixed sequence, one edge each
        step("mix_adv",    1'b0, 1'b1, 1'b1, 3'b010, 3'b010);
        e = EDGE ? 3'b010 : 3'b001;
        step("mix_ret",    1'b0, 1'b0, 1'b1, e, e);
        step("mix_nostep", 1'b0, 1'b1, 1'b0, e, e);

        // 6: reach S3 with isolated pulses, reset mid-operation, resume
        step("pre_rst",    1'b1, 1'b0, 1'b0, 3'b001, 3'b001);
        step("to_s2",      1'b0, 1'b1, 1'b1, 3'b010, 3'b010);
        step("gap1",       1'b0, 1'b1, 1'b0, 3'b010, 3'b010);
        step("to_s3",      1'b0, 1'b1, 1'b1, 3'b100, 3'b100);
        step("gap2",       1'b0, 1'b1, 1'b0, 3'b100, 3'b100);
        step("mid_rst",    1'b1, 1'b1, 1'b1, 3'b001, 3'b001);
        step("resume1",    1'b0, 1'b1, 1'b1, 3'b010, 3'b010);
        e = EDGE ? 3'b010 : 3'b100;
        step("resume2",    1'b0, 1'b1, 1'b1, e, e);
        step("resume_hold",1'b0, 1'b1, 1'b0, e, e);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
